// File: rtl/instruction_fetch.sv
// Instruction fetch: walks program memory one byte per cycle, assembles 1/2-byte
// instructions and queues them in a 2-entry FIFO for the decode/execute stage.
module instruction_fetch #(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] address_bus,
   input  logic [7:0] data_bus,
   output logic       instr_valid,
   input  logic       instr_ready,
   output logic [7:0] instr_opcode,
   output logic [7:0] instr_imm,
   output logic       instr_len2,
   output logic [7:0] instr_pc,
   input  logic       redirect_valid,
   input  logic [7:0] redirect_addr
);

   typedef enum logic {
      ST_OP  = 1'b0,
      ST_IMM = 1'b1
   } state_t;

   typedef struct packed {
      logic [7:0] op;
      logic [7:0] imm;
      logic       len2;
      logic [7:0] pc;
   } entry_t;

   state_t     state_reg, state_next;
   logic [7:0] pc_reg, pc_next;
   logic [7:0] op_reg, op_next;
   logic [7:0] op_pc_reg, op_pc_next;
   logic [1:0] count_reg, count_next;
   logic       rd_ptr_reg, rd_ptr_next;
   entry_t     fifo_reg [DEPTH];

   logic       pop;
   logic       space;
   logic       push;
   entry_t     push_entry;
   logic       wr_idx;
   entry_t     head;

   // MOV/CMP immediate (1000xxxx) and branches (101xxxxx) carry a second byte.
   function automatic logic is_two_byte(input logic [7:0] b);
      return (b[7:4] == 4'b1000) || (b[7:5] == 3'b101);
   endfunction

   // Tail slot; when full it aliases the head, which is being popped that cycle.
   assign wr_idx = rd_ptr_reg ^ count_reg[0];
   assign head   = fifo_reg[rd_ptr_reg];

   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      op_next     = op_reg;
      op_pc_next  = op_pc_reg;
      push        = 1'b0;
      push_entry  = '0;
      pop         = (count_reg != 2'd0) && instr_ready;
      space       = (count_reg < 2'(DEPTH)) || pop;
      rd_ptr_next = pop ? ~rd_ptr_reg : rd_ptr_reg;

      case (state_reg)
         ST_OP: begin
            if (space) begin
               op_next    = data_bus;
               op_pc_next = pc_reg;
               pc_next    = pc_reg + 8'd1;
               if (is_two_byte(data_bus)) begin
                  state_next = ST_IMM;
               end else begin
                  push       = 1'b1;
                  push_entry = '{op: data_bus, imm: 8'h00, len2: 1'b0, pc: pc_reg};
               end
            end
         end
         ST_IMM: begin
            if (space) begin
               push       = 1'b1;
               push_entry = '{op: op_reg, imm: data_bus, len2: 1'b1, pc: op_pc_reg};
               pc_next    = pc_reg + 8'd1;
               state_next = ST_OP;
            end
         end
         default: state_next = ST_OP;
      endcase

      count_next = count_reg + {1'b0, push} - {1'b0, pop};

      // A taken branch discards everything in flight, including a half-built instruction.
      if (redirect_valid) begin
         state_next  = ST_OP;
         pc_next     = redirect_addr;
         count_next  = 2'd0;
         push        = 1'b0;
         rd_ptr_next = rd_ptr_reg;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= ST_OP;
         pc_reg     <= 8'h00;
         op_reg     <= 8'h00;
         op_pc_reg  <= 8'h00;
         count_reg  <= 2'd0;
         rd_ptr_reg <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_reg[i] <= '0;
         end
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         op_reg     <= op_next;
         op_pc_reg  <= op_pc_next;
         count_reg  <= count_next;
         rd_ptr_reg <= rd_ptr_next;
         if (push) begin
            fifo_reg[wr_idx] <= push_entry;
         end
      end
   end

   assign address_bus  = pc_reg;
   assign instr_valid  = (count_reg != 2'd0);
   assign instr_opcode = head.op;
   assign instr_imm    = head.imm;
   assign instr_len2   = head.len2;
   assign instr_pc     = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-cycle vector table plus hand-written
// reset and full-FIFO sequences against a behavioural program memory.
module tb_instruction_fetch;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] address_bus;
   logic [7:0] data_bus;
   logic       instr_valid;
   logic       instr_ready = 1'b0;
   logic [7:0] instr_opcode;
   logic [7:0] instr_imm;
   logic       instr_len2;
   logic [7:0] instr_pc;
   logic       redirect_valid = 1'b0;
   logic [7:0] redirect_addr = 8'h00;

   logic [7:0] rom [256];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   assign data_bus = rom[address_bus];

   instruction_fetch #(.DEPTH(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .address_bus    (address_bus),
      .data_bus       (data_bus),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_opcode   (instr_opcode),
      .instr_imm      (instr_imm),
      .instr_len2     (instr_len2),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr)
   );

   typedef struct {
      logic       ready;
      logic       rv;
      logic [7:0] raddr;
      logic       valid;
      logic [7:0] op;
      logic [7:0] imm;
      logic       len2;
      logic [7:0] pc;
      logic [7:0] addr;
   } vec_t;

   vec_t vecs [28];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic check_head(input string tag, input logic v, input logic [7:0] op,
                             input logic [7:0] imm, input logic l2, input logic [7:0] pc,
                             input logic [7:0] addr);
      check({tag, " valid"}, {7'd0, instr_valid}, {7'd0, v});
      check({tag, " addr"}, address_bus, addr);
      if (v) begin
         check({tag, " op"}, instr_opcode, op);
         check({tag, " imm"}, instr_imm, imm);
         check({tag, " len2"}, {7'd0, instr_len2}, {7'd0, l2});
         check({tag, " pc"}, instr_pc, pc);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
   endtask

   // Reset pulse spanning one edge; returns at a falling edge with reset released.
   task automatic do_reset();
      reset = 1'b0;
      instr_ready = 1'b0;
      redirect_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_vecs(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         instr_ready    = vecs[i].ready;
         redirect_valid = vecs[i].rv;
         redirect_addr  = vecs[i].raddr;
         @(posedge clk);
         @(negedge clk);
         $display("vec %0d: valid=%0d op=%02h imm=%02h len2=%0d pc=%02h addr=%02h", i,
                  instr_valid, instr_opcode, instr_imm, instr_len2, instr_pc, address_bus);
         check_head($sformatf("vec%0d", i), vecs[i].valid, vecs[i].op, vecs[i].imm,
                    vecs[i].len2, vecs[i].pc, vecs[i].addr);
      end
      redirect_valid = 1'b0;
   endtask

   initial begin
      // Straight line, ready=1 (ROM 81 00 98 61 00...)
      vecs[0]  = '{1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h01};
      vecs[1]  = '{1, 0, 8'h00, 1, 8'h81, 8'h00, 1, 8'h00, 8'h02};
      vecs[2]  = '{1, 0, 8'h00, 1, 8'h98, 8'h00, 0, 8'h02, 8'h03};
      vecs[3]  = '{1, 0, 8'h00, 1, 8'h61, 8'h00, 0, 8'h03, 8'h04};
      vecs[4]  = '{1, 0, 8'h00, 1, 8'h00, 8'h00, 0, 8'h04, 8'h05};
      // Backpressure (ROM 98 61 91 00...)
      vecs[5]  = '{0, 0, 8'h00, 1, 8'h98, 8'h00, 0, 8'h00, 8'h01};
      vecs[6]  = '{0, 0, 8'h00, 1, 8'h98, 8'h00, 0, 8'h00, 8'h02};
      vecs[7]  = '{0, 0, 8'h00, 1, 8'h98, 8'h00, 0, 8'h00, 8'h02};
      vecs[8]  = '{0, 0, 8'h00, 1, 8'h98, 8'h00, 0, 8'h00, 8'h02};
      vecs[9]  = '{1, 0, 8'h00, 1, 8'h61, 8'h00, 0, 8'h01, 8'h03};
      vecs[10] = '{1, 0, 8'h00, 1, 8'h91, 8'h00, 0, 8'h02, 8'h04};
      vecs[11] = '{1, 0, 8'h00, 1, 8'h00, 8'h00, 0, 8'h03, 8'h05};
      // Redirect / wrap (ROM 1A 02 03 05 98 10 ... FF:A8)
      vecs[12] = '{1, 0, 8'h00, 1, 8'h1A, 8'h00, 0, 8'h00, 8'h01};
      vecs[13] = '{1, 0, 8'h00, 1, 8'h02, 8'h00, 0, 8'h01, 8'h02};
      vecs[14] = '{1, 1, 8'h04, 0, 8'h00, 8'h00, 0, 8'h00, 8'h04};
      vecs[15] = '{1, 0, 8'h00, 1, 8'h98, 8'h00, 0, 8'h04, 8'h05};
      vecs[16] = '{1, 0, 8'h00, 1, 8'h10, 8'h00, 0, 8'h05, 8'h06};
      vecs[17] = '{1, 1, 8'hFF, 0, 8'h00, 8'h00, 0, 8'h00, 8'hFF};
      vecs[18] = '{1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00};
      vecs[19] = '{1, 0, 8'h00, 1, 8'hA8, 8'h1A, 1, 8'hFF, 8'h01};
      vecs[20] = '{1, 0, 8'h00, 1, 8'h02, 8'h00, 0, 8'h01, 8'h02};
      vecs[21] = '{1, 1, 8'hFF, 0, 8'h00, 8'h00, 0, 8'h00, 8'hFF};
      vecs[22] = '{1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00};
      vecs[23] = '{1, 1, 8'h04, 0, 8'h00, 8'h00, 0, 8'h00, 8'h04};
      vecs[24] = '{1, 0, 8'h00, 1, 8'h98, 8'h00, 0, 8'h04, 8'h05};
      vecs[25] = '{0, 0, 8'h00, 1, 8'h98, 8'h00, 0, 8'h04, 8'h06};
      vecs[26] = '{0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00};
      vecs[27] = '{1, 0, 8'h00, 1, 8'h1A, 8'h00, 0, 8'h00, 8'h01};

      // Reset state, then reset pulsed mid-IMM
      clear_rom();
      rom[0] = 8'h81; rom[1] = 8'h00; rom[2] = 8'h98; rom[3] = 8'h61;
      #2;
      check_head("reset", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
      check("reset op", instr_opcode, 8'h00);
      check("reset imm", instr_imm, 8'h00);
      check("reset len2", {7'd0, instr_len2}, 8'h00);
      check("reset pc", instr_pc, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      instr_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_head("pre-reset imm", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h01);
      #2 reset = 1'b0;
      #1;
      check("async reset addr", address_bus, 8'h00);
      check("async reset valid", {7'd0, instr_valid}, 8'h00);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      $display("reset mid-IMM released");
      run_vecs(0, 4);

      clear_rom();
      rom[0] = 8'h98; rom[1] = 8'h61; rom[2] = 8'h91;
      do_reset();
      run_vecs(5, 11);

      clear_rom();
      rom[0] = 8'h1A; rom[1] = 8'h02; rom[2] = 8'h03; rom[3] = 8'h05;
      rom[4] = 8'h98; rom[5] = 8'h10; rom[255] = 8'hA8;
      do_reset();
      run_vecs(12, 27);

      // Full FIFO with simultaneous pop and push every cycle
      clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = 8'(8'h10 + i);
      do_reset();
      instr_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_head("full fill", 1'b1, 8'h10, 8'h00, 1'b0, 8'h00, 8'h02);
      instr_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         $display("full pop/push %0d: op=%02h pc=%02h addr=%02h", k, instr_opcode, instr_pc,
                  address_bus);
         check_head($sformatf("full%0d", k), 1'b1, 8'(8'h10 + k), 8'h00, 1'b0, 8'(k),
                    8'(2 + k));
      end
      instr_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_head("full hold", 1'b1, 8'h14, 8'h00, 1'b0, 8'h04, 8'h06);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
